pipelined_addsub: RTL
=====================

# pipelined_addsub

Parametrised, pipelined integer add/subtract unit with a valid/ready handshake, carry and signed-overflow flags, and optional signed saturation. It generalises the pipeline's single-cycle 32-bit combinational adder. The carry chain is split across `STAGES` register stages so wide operands close timing. It serves the execute stage and future DSP-style (saturating) extensions of the core.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width in bits; must be ≥ 2 and divisible by `STAGES`.
- `STAGES`, 2, number of pipeline register stages (≥ 1). Chunk width is `CW = WIDTH/STAGES`.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  unit accepts a beat this cycle.
- `A`  in  WIDTH  operand A, two's complement.
- `B`  in  WIDTH  operand B, two's complement.
- `sub`  in  1  0: A+B, 1: A−B.
- `sat`  in  1  1: saturate signed result on overflow.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts result.
- `Y`  out  WIDTH  result.
- `carry`  out  1  carry-out of the MSB of the internal add (for `sub`, 1 = no borrow, i.e. A ≥ B unsigned).
- `overflow`  out  1  signed overflow of the unsaturated result.

## Operation
- Internal operation: `A + (sub ? ~B : B) + sub`, over WIDTH bits plus carry-out.
- Stage k (k = 0..STAGES−1) adds chunk k, bits [k·CW +: CW], LSB chunk first, using the carry registered from stage k−1. Stage 0 uses carry-in = `sub`.
- Per-stage registers hold:
  - valid bit;
  - result chunks 0..k;
  - chunk carry-out;
  - remaining upper operand chunks (B already conditionally inverted);
  - `sat`;
  - A[WIDTH−1] and effective B[WIDTH−1].
- Final stage, combinationally before its register:
  - `overflow` = (a_msb == b_eff_msb) && (sum_msb != a_msb);
  - `carry` = final chunk carry-out.
  - If `sat` && `overflow`: Y = a_msb ? signed min (1 followed by zeros) : signed max (0 followed by ones). Otherwise Y = raw sum.
  - `overflow` always reports the raw condition, even when saturated.
- `carry` and `overflow` are computed identically whether or not `sat` is set.
- The stage-(STAGES−1) register drives `Y`, `carry`, `overflow` and `out_valid` directly. There is no combinational path from inputs to these outputs.
- Global stall:
  - `adv = !out_valid || out_ready`;
  - `in_ready = adv`, a combinational path from `out_ready` to `in_ready`, documented and accepted.
  - When `adv` = 1, all stages shift by one. Stage 0 loads `in_valid && in_ready`.
  - When `adv` = 0, all stage registers hold.
- Bubbles are not compressed. An invalid stage still takes one shift to drain.
- Data registers of invalid stages may take any value. Only `Y`, `carry` and `overflow` carry a reset requirement.

## Timing
- Reset (synchronous, `reset` = 1 at a rising edge): all valid bits = 0, `out_valid` = 0, `Y` = 0, `carry` = 0, `overflow` = 0. `in_ready` = 1 in the following cycle.
- Reset mid-operation flushes every in-flight beat. No result of a beat accepted before or during the reset cycle ever appears.
- A beat accepted at edge t (`in_valid && in_ready` sampled high) appears with `out_valid` = 1 after edge t+STAGES−1 when no stall occurs. Latency is STAGES cycles; STAGES = 1 gives a result in the cycle after acceptance.
- Throughput: one beat per cycle while `out_ready` = 1.
- While `out_valid && !out_ready`, `Y`, `carry`, `overflow` and `out_valid` stay stable, and `in_ready` = 0.
- Simultaneous output handoff and input acceptance in the same cycle is legal when `out_ready` = 1.
- `in_valid` may be deasserted at any time. A beat is taken only on an edge where `in_valid && in_ready`.

## Test plan
- **Reset**: reset mid-stream with 2 beats in flight → no `out_valid` afterwards, outputs 0, `in_ready` = 1 one cycle after reset releases.
- **Basic add** (WIDTH = 32, STAGES = 2): A = 0x0000FFFF, B = 0x00000001, sub = 0 → Y = 0x00010000, carry = 0, overflow = 0. `out_valid` rises 2 cycles after acceptance, exercising the cross-chunk carry.
- **Subtract / borrow**: A = 5, B = 7, sub = 1 → Y = 0xFFFFFFFE, carry = 0. A = 7, B = 5 → Y = 2, carry = 1.
- **Overflow and saturation**: A = 0x7FFFFFFF, B = 1, add:
  - sat = 0 → Y = 0x80000000, overflow = 1;
  - sat = 1 → Y = 0x7FFFFFFF, overflow = 1.
  - Also A = 0x80000000, B = 1, sub = 1, sat = 1 → Y = 0x80000000, overflow = 1.
- **Backpressure**: stream 8 beats (A = i, B = 10·i) with `out_ready` toggling in a pseudo-random pattern → results arrive in order with no loss or duplication, outputs stable while stalled, `in_ready` = 0 whenever `out_valid && !out_ready`.
- **Parameter sweep**: (WIDTH, STAGES) = (8, 1), (16, 4), (64, 8), 1000 random beats each → results match a reference model (Y, carry, overflow, sat), latency = STAGES under `out_ready` = 1.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract. The carry chain is split into STAGES chunks,
// with one register stage per chunk, plus a valid/ready handshake and optional signed saturation.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             carry,
  output logic             overflow
);
  localparam int CW = WIDTH / STAGES;

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic             c_q     [STAGES];
  logic             c_d     [STAGES];
  logic             sat_q   [STAGES];
  logic             sat_d   [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  logic             adv;
  logic             src_valid;
  logic             src_c;
  logic             src_sat;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_sum;
  logic [CW:0]      chunk;

  // The whole pipeline stalls together, so in_ready depends combinationally on out_ready.
  assign adv      = !valid_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    src_valid = in_valid && adv;
    src_a     = A;
    src_b     = sub ? ~B : B;
    src_sum   = '0;
    src_c     = sub;
    src_sat   = sat;
    chunk     = '0;
    ovf_d     = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, src_a[k*CW +: CW]} + {1'b0, src_b[k*CW +: CW]} + {{CW{1'b0}}, src_c};
      valid_d[k] = src_valid;
      a_d[k]     = src_a;
      b_d[k]     = src_b;
      sat_d[k]   = src_sat;
      c_d[k]     = chunk[CW];
      sum_d[k]   = src_sum;
      sum_d[k][k*CW +: CW] = chunk[CW-1:0];
      src_valid = valid_q[k];
      src_a     = a_q[k];
      src_b     = b_q[k];
      src_sum   = sum_q[k];
      src_c     = c_q[k];
      src_sat   = sat_q[k];
    end
    // Overflow is always the raw condition; saturation only replaces the stored sum.
    ovf_d = (a_d[STAGES-1][WIDTH-1] == b_d[STAGES-1][WIDTH-1]) &&
            (sum_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
    if (sat_d[STAGES-1] && ovf_d) begin
      sum_d[STAGES-1] = a_d[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        c_q[k]     <= 1'b0;
        sat_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        sum_q[k]   <= sum_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        c_q[k]     <= c_d[k];
        sat_q[k]   <= sat_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign Y         = sum_q[STAGES-1];
  assign carry     = c_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule
